hazard_md_unit: RTL and testbench
=================================

Name: hazard_md_unit

Overview:
- Parametrised successor to the five-stage hazard/forwarding unit.
- Adds multiply/divide (HI/LO) instruction classes and a sequential MD busy tracker.
- Adds a compile-time no-forwarding mode, and fixes load-in-W forwarding.
- Sits beside the datapath: reads per-stage instruction words and decoder class codes; drives the D-stage stall and the forwarding-mux selects.

Parameters:
- MULT_CYCLES, 5, cycles the MD unit is busy after a mult/multu leaves E (1..63).
- DIV_CYCLES, 10, cycles the MD unit is busy after a div/divu leaves E (1..63).
- FWD_EN, 1, 1 = full forwarding; 0 = forwarding disabled, resolve every RAW hazard by stalling.
- LINK_REG, 31, register written by jal.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- InstrD/InstrE/InstrM/InstrW  in  32 each  instruction word per stage (rs 25:21, rt 20:16, rd 15:11, funct 5:0)
- TypeD/TypeE/TypeM/TypeW  in  4 each  decoder class per stage:
  - 0 other, 1 cal_r, 2 cal_i, 3 branch, 4 load, 5 jr, 6 jal, 7 store
  - 8 md (mult/div), 9 mf (mfhi/mflo), 10 mt (mthi/mtlo)
- stall  out  1  freeze PC and D register; insert bubble into E
- ForwardRSD, ForwardRTD  out  2 each  0 regfile, 1 E PC+8, 2 M ALU, 3 M PC+8
- ForwardRSE, ForwardRTE  out  3 each  0 none, 1 M ALU, 2 M PC+8, 3 W PC+8, 4 W result
- ForwardRTM  out  2  0 none, 1 W PC+8, 2 W result
- md_busy  out  1  MD unit computing
- md_cnt  out  6  remaining busy cycles

Behaviour:
- Writers and destination registers:
  - cal_r and mf write rd. cal_i and load write rt. jal writes LINK_REG.
  - Destination 0 never matches.
- Source registers read per class:
  - branch: rs, rt. jr and mt: rs.
  - cal_r and md: rs, rt. cal_i and load: rs.
  - store: rs at E, rt at M.
- Need stage:
  - branch and jr need operands in D.
  - All other classes need operands in E; store rt is needed in M.
- Stall with FWD_EN=1 (any condition true stalls):
  - D needs a source and a cal_r/cal_i/mf/load in E writes it.
  - D needs a source and a load in M writes it.
  - E-need class in D reads a register a load in E writes.
- Stall with FWD_EN=0:
  - Stall if any D source matches the destination of any writer in E or M.
  - All Forward* outputs held at 0.
  - Register file is write-before-read, so W never stalls.
- Forward selects (FWD_EN=1), combinational:
  - Nearest stage has priority: E > M > W.
  - Only for classes that consume that operand in that stage; a mismatch gives 0.
  - Code 4 (and ForwardRTM code 2) applies to a cal_r/cal_i/mf/load writer in W.
- MD tracker, state IDLE/BUSY:
  - In IDLE, TypeE==8 on a rising edge loads md_cnt with DIV_CYCLES if InstrE funct is 0x1A or 0x1B, else MULT_CYCLES; state goes to BUSY.
  - In BUSY, md_cnt decrements by 1 each cycle; on reaching 0 state returns to IDLE.
  - md_busy = (md_cnt != 0).
  - An md in E while BUSY cannot occur, because of the md stall rule below.
- MD stall:
  - Stall when TypeD is 8, 9 or 10 and either TypeE==8 or md_cnt != 0.
  - mf/mt in D may issue the cycle md_cnt reads 0.
- stall is the OR of all stall terms.
- stall does not affect the counter; E bubbles carry Type 0.
- Reset:
  - Asynchronous reset: md_cnt=0, state IDLE, md_busy=0, immediately, including mid-operation.
  - Combinational outputs follow their inputs during reset.

Test Plan:
- mult $1,$2 in E, mflo in D, MULT_CYCLES=5:
  - mflo stalls 6 consecutive cycles (E cycle plus 5 busy).
  - md_cnt reads 5,4,3,2,1,0; mflo issues on the cycle md_cnt=0.
- divu in E (funct 0x1B), DIV_CYCLES=10: md_cnt loads 10.
  - Assert reset when md_cnt=4: md_cnt=0 and md_busy=0 with no clock edge.
  - Deassert reset: a waiting mfhi issues next cycle.
- lw $3 in E, beq $3,$4 in D: stall=1.
  - Next cycle lw in M: stall=1.
  - Next cycle lw in W: stall=0, ForwardRSD=0.
- addu $5 in M, add $6,$5,$5 in E: ForwardRSE=1 and ForwardRTE=1.
  - Repeat with lw $5 in W: ForwardRSE=4.
  - Repeat with $0 as destination: both selects 0.
- jal in E, jr $31 in D: ForwardRSD=1.
  - Next cycle jal in M: ForwardRSD=3.
  - sw $31 in M with jal in W: ForwardRTM=1.
- FWD_EN=0, addu $7 in M, or $8,$7,$1 in D: stall=1, all Forward*=0.
  - Once addu reaches W: stall=0.

Source files
------------

// File: rtl/hazard_md_unit.sv
// Hazard detection and forwarding-select unit for a five-stage pipeline.
// It also tracks the sequential multiply/divide (HI/LO) unit and stalls its consumers.
module hazard_md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter bit          FWD_EN      = 1'b1,
    parameter int unsigned LINK_REG    = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] InstrE,
    input  logic [31:0] InstrM,
    input  logic [31:0] InstrW,
    input  logic [3:0]  TypeD,
    input  logic [3:0]  TypeE,
    input  logic [3:0]  TypeM,
    input  logic [3:0]  TypeW,
    output logic        stall,
    output logic [1:0]  ForwardRSD,
    output logic [1:0]  ForwardRTD,
    output logic [2:0]  ForwardRSE,
    output logic [2:0]  ForwardRTE,
    output logic [1:0]  ForwardRTM,
    output logic        md_busy,
    output logic [5:0]  md_cnt
);

    localparam logic [3:0] T_CALR   = 4'd1;
    localparam logic [3:0] T_CALI   = 4'd2;
    localparam logic [3:0] T_BRANCH = 4'd3;
    localparam logic [3:0] T_LOAD   = 4'd4;
    localparam logic [3:0] T_JR     = 4'd5;
    localparam logic [3:0] T_JAL    = 4'd6;
    localparam logic [3:0] T_STORE  = 4'd7;
    localparam logic [3:0] T_MD     = 4'd8;
    localparam logic [3:0] T_MF     = 4'd9;
    localparam logic [3:0] T_MT     = 4'd10;

    localparam logic [4:0] LINK    = 5'(LINK_REG);
    localparam logic [5:0] MULT_LD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LD  = 6'(DIV_CYCLES);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    function automatic logic [4:0] dest_of(input logic [3:0] t, input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [4:0] r;
        case (t)
            T_CALR, T_MF:   r = rd;
            T_CALI, T_LOAD: r = rt;
            T_JAL:          r = LINK;
            default:        r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic logic alu_wr(input logic [3:0] t);
        return (t == T_CALR) || (t == T_CALI) || (t == T_MF);
    endfunction

    function automatic logic result_wr(input logic [3:0] t);
        return alu_wr(t) || (t == T_LOAD);
    endfunction

    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

    // Which operands each class consumes, and in which stage it consumes them.
    function automatic logic rs_used_d(input logic [3:0] t);
        return (t == T_BRANCH) || (t == T_JR);
    endfunction

    function automatic logic rt_used_d(input logic [3:0] t);
        return t == T_BRANCH;
    endfunction

    function automatic logic rs_used_e(input logic [3:0] t);
        return (t == T_CALR) || (t == T_CALI) || (t == T_LOAD) || (t == T_STORE) ||
               (t == T_MD) || (t == T_MT);
    endfunction

    function automatic logic rt_used_e(input logic [3:0] t);
        return (t == T_CALR) || (t == T_MD);
    endfunction

    function automatic logic rt_used_m(input logic [3:0] t);
        return t == T_STORE;
    endfunction

    // The nearest matching writer decides the select; a writer with no usable path gives 0.
    function automatic logic [1:0] fwd_d_sel(input logic hit_e, input logic hit_m,
                                             input logic [3:0] te, input logic [3:0] tm);
        logic [1:0] s;
        s = 2'd0;
        if (hit_e) begin
            s = (te == T_JAL) ? 2'd1 : 2'd0;
        end else if (hit_m) begin
            if (alu_wr(tm))       s = 2'd2;
            else if (tm == T_JAL) s = 2'd3;
        end
        return s;
    endfunction

    function automatic logic [2:0] fwd_e_sel(input logic hit_m, input logic hit_w,
                                             input logic [3:0] tm, input logic [3:0] tw);
        logic [2:0] s;
        s = 3'd0;
        if (hit_m) begin
            if (alu_wr(tm))       s = 3'd1;
            else if (tm == T_JAL) s = 3'd2;
        end else if (hit_w) begin
            if (tw == T_JAL)        s = 3'd3;
            else if (result_wr(tw)) s = 3'd4;
        end
        return s;
    endfunction

    function automatic logic [1:0] fwd_m_sel(input logic hit_w, input logic [3:0] tw);
        logic [1:0] s;
        s = 2'd0;
        if (hit_w) begin
            if (tw == T_JAL)        s = 2'd1;
            else if (result_wr(tw)) s = 2'd2;
        end
        return s;
    endfunction

    logic [4:0] rs_d, rt_d, rs_e, rt_e, rt_m;
    logic [4:0] dst_e, dst_m, dst_w;
    logic       hit_e_rsd, hit_e_rtd, hit_m_rsd, hit_m_rtd;
    logic       hit_m_rse, hit_m_rte, hit_w_rse, hit_w_rte, hit_w_rtm;
    logic       stall_fwd_d, stall_fwd_e, stall_nofwd, stall_md;
    logic       unused_instr_bits;

    assign rs_d  = InstrD[25:21];
    assign rt_d  = InstrD[20:16];
    assign rs_e  = InstrE[25:21];
    assign rt_e  = InstrE[20:16];
    assign rt_m  = InstrM[20:16];
    assign dst_e = dest_of(TypeE, InstrE[20:16], InstrE[15:11]);
    assign dst_m = dest_of(TypeM, InstrM[20:16], InstrM[15:11]);
    assign dst_w = dest_of(TypeW, InstrW[20:16], InstrW[15:11]);

    assign unused_instr_bits = ^{InstrD[31:26], InstrD[15:0], InstrE[31:26], InstrE[10:6],
                                 InstrM[31:21], InstrM[10:0], InstrW[31:21], InstrW[10:0]};

    always_comb begin
        hit_e_rsd = hit(rs_d, dst_e);
        hit_e_rtd = hit(rt_d, dst_e);
        hit_m_rsd = hit(rs_d, dst_m);
        hit_m_rtd = hit(rt_d, dst_m);
        hit_m_rse = hit(rs_e, dst_m);
        hit_m_rte = hit(rt_e, dst_m);
        hit_w_rse = hit(rs_e, dst_w);
        hit_w_rte = hit(rt_e, dst_w);
        hit_w_rtm = hit(rt_m, dst_w);
    end

    // Branch/jr operands are consumed in D: ALU results are only ready from M, loads from W.
    always_comb begin
        stall_fwd_d = (rs_used_d(TypeD) &&
                       ((hit_e_rsd && result_wr(TypeE)) || (hit_m_rsd && TypeM == T_LOAD))) ||
                      (rt_used_d(TypeD) &&
                       ((hit_e_rtd && result_wr(TypeE)) || (hit_m_rtd && TypeM == T_LOAD)));
        stall_fwd_e = (TypeE == T_LOAD) &&
                      ((rs_used_e(TypeD) && hit_e_rsd) || (rt_used_e(TypeD) && hit_e_rtd));
        stall_nofwd = ((rs_used_d(TypeD) || rs_used_e(TypeD)) && (hit_e_rsd || hit_m_rsd)) ||
                      ((rt_used_d(TypeD) || rt_used_e(TypeD) || rt_used_m(TypeD)) &&
                       (hit_e_rtd || hit_m_rtd));
        stall_md    = ((TypeD == T_MD) || (TypeD == T_MF) || (TypeD == T_MT)) &&
                      ((TypeE == T_MD) || (md_cnt != 6'd0));
        stall       = stall_md | (FWD_EN ? (stall_fwd_d | stall_fwd_e) : stall_nofwd);
    end

    always_comb begin
        ForwardRSD = 2'd0;
        ForwardRTD = 2'd0;
        ForwardRSE = 3'd0;
        ForwardRTE = 3'd0;
        ForwardRTM = 2'd0;
        if (FWD_EN) begin
            if (rs_used_d(TypeD)) ForwardRSD = fwd_d_sel(hit_e_rsd, hit_m_rsd, TypeE, TypeM);
            if (rt_used_d(TypeD)) ForwardRTD = fwd_d_sel(hit_e_rtd, hit_m_rtd, TypeE, TypeM);
            if (rs_used_e(TypeE)) ForwardRSE = fwd_e_sel(hit_m_rse, hit_w_rse, TypeM, TypeW);
            if (rt_used_e(TypeE)) ForwardRTE = fwd_e_sel(hit_m_rte, hit_w_rte, TypeM, TypeW);
            if (rt_used_m(TypeM)) ForwardRTM = fwd_m_sel(hit_w_rtm, TypeW);
        end
    end

    md_state_t  md_state_q, md_state_d;
    logic [5:0] md_cnt_q, md_cnt_d;

    // The busy window opens as the md instruction leaves E; stall never holds the count.
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        case (md_state_q)
            MD_IDLE: begin
                if (TypeE == T_MD) begin
                    md_cnt_d   = (InstrE[5:0] == 6'h1A || InstrE[5:0] == 6'h1B) ? DIV_LD : MULT_LD;
                    md_state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q <= 6'd1) begin
                    md_cnt_d   = 6'd0;
                    md_state_d = MD_IDLE;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end
            default: begin
                md_cnt_d   = 6'd0;
                md_state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= 6'd0;
        end else begin
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

    assign md_cnt  = md_cnt_q;
    assign md_busy = (md_cnt_q != 6'd0);

endmodule

// File: tb/tb_hazard_md_unit.sv
// Scoreboard bench for hazard_md_unit: one forwarding and one no-forwarding instance share stimulus;
// expectations come from an operand-readiness model of the pipeline.
module tb_hazard_md_unit;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;
    localparam int LINK   = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins[4];
    logic [3:0]  typ[4];

    logic       f_stall, f_busy, n_stall, n_busy;
    logic [1:0] f_rsd, f_rtd, f_rtm, n_rsd, n_rtd, n_rtm;
    logic [2:0] f_rse, f_rte, n_rse, n_rte;
    logic [5:0] f_cnt, n_cnt;

    always #5 clk = ~clk;

    hazard_md_unit #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .FWD_EN(1'b1), .LINK_REG(LINK)) u_fwd (
        .clk(clk), .reset(reset),
        .InstrD(ins[0]), .InstrE(ins[1]), .InstrM(ins[2]), .InstrW(ins[3]),
        .TypeD(typ[0]), .TypeE(typ[1]), .TypeM(typ[2]), .TypeW(typ[3]),
        .stall(f_stall), .ForwardRSD(f_rsd), .ForwardRTD(f_rtd), .ForwardRSE(f_rse),
        .ForwardRTE(f_rte), .ForwardRTM(f_rtm), .md_busy(f_busy), .md_cnt(f_cnt)
    );

    hazard_md_unit #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .FWD_EN(1'b0), .LINK_REG(LINK)) u_nof (
        .clk(clk), .reset(reset),
        .InstrD(ins[0]), .InstrE(ins[1]), .InstrM(ins[2]), .InstrW(ins[3]),
        .TypeD(typ[0]), .TypeE(typ[1]), .TypeM(typ[2]), .TypeW(typ[3]),
        .stall(n_stall), .ForwardRSD(n_rsd), .ForwardRTD(n_rtd), .ForwardRSE(n_rse),
        .ForwardRTE(n_rte), .ForwardRTM(n_rtm), .md_busy(n_busy), .md_cnt(n_cnt)
    );

    typedef struct packed {
        logic       stall;
        logic [1:0] rsd;
        logic [1:0] rtd;
        logic [2:0] rse;
        logic [2:0] rte;
        logic [1:0] rtm;
        logic       stall_n;
        logic       busy;
        logic [5:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   md_done = 0;

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] w;
        w = {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
        return w;
    endfunction

    function automatic int dst(input logic [3:0] t, input logic [31:0] w);
        case (t)
            4'd1, 4'd9: return int'(w[15:11]);
            4'd2, 4'd4: return int'(w[20:16]);
            4'd6:       return LINK;
            default:    return 0;
        endcase
    endfunction

    // Stage index where the operand is consumed: 0=D, 1=E, 2=M, -1=not read.
    function automatic int need_rs(input logic [3:0] t);
        case (t)
            4'd3, 4'd5:                           return 0;
            4'd1, 4'd2, 4'd4, 4'd7, 4'd8, 4'd10:  return 1;
            default:                              return -1;
        endcase
    endfunction

    function automatic int need_rt(input logic [3:0] t);
        case (t)
            4'd3:       return 0;
            4'd1, 4'd8: return 1;
            4'd7:       return 2;
            default:    return -1;
        endcase
    endfunction

    // First stage from which a writer's value can be forwarded.
    function automatic int ready_stage(input logic [3:0] t);
        case (t)
            4'd6:             return 1;
            4'd1, 4'd2, 4'd9: return 2;
            4'd4:             return 3;
            default:          return 0;
        endcase
    endfunction

    function automatic int fcode(input int cons, input int prod, input logic [3:0] t);
        bit is_alu, is_ld, is_jal;
        is_alu = (t == 4'd1) || (t == 4'd2) || (t == 4'd9);
        is_ld  = (t == 4'd4);
        is_jal = (t == 4'd6);
        if (cons == 0 && prod == 1) return is_jal ? 1 : 0;
        if (cons == 0 && prod == 2) return is_alu ? 2 : (is_jal ? 3 : 0);
        if (cons == 1 && prod == 2) return is_alu ? 1 : (is_jal ? 2 : 0);
        if (cons == 1 && prod == 3) return is_jal ? 3 : ((is_alu || is_ld) ? 4 : 0);
        if (cons == 2 && prod == 3) return is_jal ? 1 : ((is_alu || is_ld) ? 2 : 0);
        return 0;
    endfunction

    function automatic int fwd(input int cons, input int r);
        if (r == 0) return 0;
        for (int p = cons + 1; p <= 3; p++)
            if (dst(typ[p], ins[p]) == r) return fcode(cons, p, typ[p]);
        return 0;
    endfunction

    function automatic int model_cnt();
        return (md_done > cyc) ? md_done - cyc : 0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   regs[2];
        int   ns[2];
        int   cnt;
        bit   md;
        e = '0;
        regs[0] = int'(ins[0][25:21]);
        regs[1] = int'(ins[0][20:16]);
        ns[0]   = need_rs(typ[0]);
        ns[1]   = need_rt(typ[0]);
        for (int o = 0; o < 2; o++) begin
            if (ns[o] >= 0 && regs[o] != 0) begin
                for (int p = 1; p <= 2; p++) begin
                    if (dst(typ[p], ins[p]) == regs[o]) begin
                        e.stall_n = 1'b1;
                        if (p + ns[o] < ready_stage(typ[p])) e.stall = 1'b1;
                    end
                end
            end
        end
        cnt = model_cnt();
        md  = (typ[0] == 4'd8 || typ[0] == 4'd9 || typ[0] == 4'd10) && (typ[1] == 4'd8 || cnt != 0);
        e.stall   = e.stall | md;
        e.stall_n = e.stall_n | md;
        e.rsd  = (need_rs(typ[0]) == 0) ? 2'(fwd(0, int'(ins[0][25:21]))) : 2'd0;
        e.rtd  = (need_rt(typ[0]) == 0) ? 2'(fwd(0, int'(ins[0][20:16]))) : 2'd0;
        e.rse  = (need_rs(typ[1]) == 1) ? 3'(fwd(1, int'(ins[1][25:21]))) : 3'd0;
        e.rte  = (need_rt(typ[1]) == 1) ? 3'(fwd(1, int'(ins[1][20:16]))) : 3'd0;
        e.rtm  = (need_rt(typ[2]) == 2) ? 2'(fwd(2, int'(ins[2][20:16]))) : 2'd0;
        e.busy = (cnt != 0);
        e.cnt  = 6'(cnt);
        return e;
    endfunction

    // Rising edge: an md leaving E while the unit is free opens a busy window.
    function automatic void model_edge();
        if (!reset && model_cnt() == 0 && typ[1] == 4'd8)
            md_done = cyc + 1 + ((ins[1][5:0] == 6'h1A || ins[1][5:0] == 6'h1B) ? DIV_C : MULT_C);
        cyc++;
        if (reset) md_done = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic finish_cycle(input bit pulse);
        if (pulse) begin
            #1;
            reset   = 1'b1;
            md_done = 0;
        end
        sb_q.push_back(predict());
        if (pulse) begin
            #5;
            reset = 1'b0;
        end
    endtask

    task automatic step(input int td, input int te, input int tm, input int tw,
                        input logic [31:0] id, input logic [31:0] ie,
                        input logic [31:0] im, input logic [31:0] iw, input bit pulse);
        tick();
        typ[0] = 4'(td); typ[1] = 4'(te); typ[2] = 4'(tm); typ[3] = 4'(tw);
        ins[0] = id;     ins[1] = ie;     ins[2] = im;     ins[3] = iw;
        finish_cycle(pulse);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 3;
            default: return 31;
        endcase
    endfunction

    task automatic rand_step();
        int t;
        int fn;
        tick();
        for (int i = 0; i < 4; i++) begin
            t = int'($urandom_range(0, 10));
            if (i == 1 && t == 8 && model_cnt() != 0) t = 1;
            fn = (t == 8) ? 24 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
            typ[i] = 4'(t);
            ins[i] = mk(pick(), pick(), pick(), fn);
        end
        finish_cycle($urandom_range(0, 99) == 0);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("fwd.stall",      8'(f_stall), 8'(mon_e.stall));
            chk("fwd.ForwardRSD", 8'(f_rsd),   8'(mon_e.rsd));
            chk("fwd.ForwardRTD", 8'(f_rtd),   8'(mon_e.rtd));
            chk("fwd.ForwardRSE", 8'(f_rse),   8'(mon_e.rse));
            chk("fwd.ForwardRTE", 8'(f_rte),   8'(mon_e.rte));
            chk("fwd.ForwardRTM", 8'(f_rtm),   8'(mon_e.rtm));
            chk("fwd.md_busy",    8'(f_busy),  8'(mon_e.busy));
            chk("fwd.md_cnt",     8'(f_cnt),   8'(mon_e.cnt));
            chk("nof.stall",      8'(n_stall), 8'(mon_e.stall_n));
            chk("nof.forwards",   8'({n_rsd, n_rtd, n_rtm}), 8'd0);
            chk("nof.forwardsE",  8'({n_rse, n_rte}), 8'd0);
            chk("nof.md_cnt",     8'({n_busy, n_cnt}), 8'({mon_e.busy, mon_e.cnt}));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mult12, divu12, mflo9, mfhi10, lw3, beq34, addu5, add655, lw5, addu0;
        logic [31:0] jal, jr31, sw31, addu7, or871;
        mult12 = mk(1, 2, 0, 'h18);
        divu12 = mk(1, 2, 0, 'h1B);
        mflo9  = mk(0, 0, 9, 'h12);
        mfhi10 = mk(0, 0, 10, 'h10);
        lw3    = mk(1, 3, 0, 0);
        beq34  = mk(3, 4, 0, 0);
        addu5  = mk(1, 2, 5, 'h21);
        add655 = mk(5, 5, 6, 'h20);
        lw5    = mk(1, 5, 0, 0);
        addu0  = mk(1, 2, 0, 'h21);
        jal    = mk(0, 0, 0, 0);
        jr31   = mk(31, 0, 0, 8);
        sw31   = mk(29, 31, 0, 0);
        addu7  = mk(1, 2, 7, 'h21);
        or871  = mk(7, 1, 8, 'h25);

        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            typ[i] = 4'd0;
            ins[i] = 32'd0;
        end

        // Reset held across edges: counter stays clear, combinational stall still follows inputs.
        step(9, 8, 0, 0, mflo9, mult12, 0, 0, 1'b0);
        step(9, 8, 0, 0, mflo9, divu12, 0, 0, 1'b0);
        #6 reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

        // mult in E with mflo waiting in D.
        step(9, 8, 0, 0, mflo9, mult12, 0, 0, 1'b0);
        repeat (6) step(9, 0, 0, 0, mflo9, 0, 0, 0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

        // divu, then an asynchronous reset pulse while md_cnt reads 4.
        step(9, 8, 0, 0, mfhi10, divu12, 0, 0, 1'b0);
        repeat (6) step(9, 0, 0, 0, mfhi10, 0, 0, 0, 1'b0);
        step(9, 0, 0, 0, mfhi10, 0, 0, 0, 1'b1);
        step(9, 0, 0, 0, mfhi10, 0, 0, 0, 1'b0);

        // Load-use into a branch.
        step(3, 4, 0, 0, beq34, lw3, 0, 0, 1'b0);
        step(3, 0, 4, 0, beq34, 0, lw3, 0, 1'b0);
        step(3, 0, 0, 4, beq34, 0, 0, lw3, 1'b0);

        // E-stage forwarding from M ALU, W load, and a $0 writer.
        step(0, 1, 1, 0, 0, add655, addu5, 0, 1'b0);
        step(0, 1, 0, 4, 0, add655, 0, lw5, 1'b0);
        step(0, 1, 1, 0, 0, add655, addu0, 0, 1'b0);

        // jal link register into jr and store.
        step(5, 6, 0, 0, jr31, jal, 0, 0, 1'b0);
        step(5, 0, 6, 0, jr31, 0, jal, 0, 1'b0);
        step(0, 0, 7, 6, 0, 0, sw31, jal, 1'b0);

        // RAW hazard without forwarding.
        step(1, 0, 1, 0, or871, 0, addu7, 0, 1'b0);
        step(1, 0, 0, 1, or871, 0, 0, addu7, 1'b0);

        repeat (2000) rand_step();

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
